// File: rtl/frame_bank_sched.sv
// Ping-pong write scheduler for the two-bank frame RAM: turns the sensor pixel stream
// into bank writes, pads the frame tail with black level and hands finished banks to the reader.
module frame_bank_sched #(
    parameter int COLS   = 250,
    parameter int ROWS   = 250,
    parameter int PIXELS = COLS * ROWS
) (
    input  logic        RESET,
    input  logic        WR_CLOCK,
    input  logic        FRAME_START,
    input  logic [7:0]  DATA,
    input  logic        DATA_WREN,
    input  logic [7:0]  ROW_NUM,
    input  logic [7:0]  COL_NUM,
    input  logic        FRAME_ACK,
    output logic        WR_EN,
    output logic [16:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic        RD_BANK,
    output logic        FRAME_READY,
    output logic [7:0]  BLACK_LVL,
    output logic [7:0]  DROP_CNT,
    output logic [1:0]  STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        w_bank_q, w_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        frame_ready_q, frame_ready_d;
    logic [7:0]  black_lvl_q, black_lvl_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [15:0] pad_ptr_q, pad_ptr_d;
    logic        wr_en_q, wr_en_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [15:0] offset;
    logic        in_range, col_last, black_pix, last_pix, drop_inc;

    assign offset    = 16'(16'(ROW_NUM) * 16'(COLS) + 16'(COL_NUM));
    assign in_range  = (32'(ROW_NUM) < ROWS) && (32'(COL_NUM) < COLS);
    assign col_last  = (32'(COL_NUM) == COLS - 1);
    assign black_pix = (ROW_NUM == 8'd0) && (COL_NUM == 8'd1);
    assign last_pix  = (32'(ROW_NUM) == ROWS - 1) && (32'(COL_NUM) == COLS - 2);

    always_comb begin
        state_d       = state_q;
        w_bank_d      = w_bank_q;
        rd_bank_d     = rd_bank_q;
        frame_ready_d = frame_ready_q;
        black_lvl_d   = black_lvl_q;
        drop_cnt_d    = drop_cnt_q;
        pad_ptr_d     = pad_ptr_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        drop_inc      = 1'b0;

        if (FRAME_ACK && frame_ready_q)
            frame_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (FRAME_START)
                    state_d = FILL;
            end
            FILL: begin
                if (FRAME_START) begin
                    drop_inc = 1'b1;
                end else if (DATA_WREN && in_range) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {w_bank_q, offset};
                    wr_data_d = col_last ? black_lvl_q : DATA;
                    if (black_pix)
                        black_lvl_d = DATA;
                    // The last real pixel of the frame hands over to tail padding.
                    if (last_pix) begin
                        state_d   = PAD;
                        pad_ptr_d = offset + 16'd1;
                    end
                end
            end
            PAD: begin
                if (FRAME_START) begin
                    drop_inc = 1'b1;
                    state_d  = FILL;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {w_bank_q, pad_ptr_q};
                    wr_data_d = black_lvl_q;
                    pad_ptr_d = pad_ptr_q + 16'd1;
                    if (32'(pad_ptr_q) == PIXELS - 1)
                        state_d = DONE;
                end
            end
            DONE: begin
                // An ACK arriving now frees the read bank just in time for the swap.
                if (!frame_ready_q || FRAME_ACK) begin
                    rd_bank_d     = w_bank_q;
                    w_bank_d      = ~w_bank_q;
                    frame_ready_d = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                end
                state_d = FRAME_START ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (drop_inc && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge WR_CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            w_bank_q      <= 1'b0;
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            black_lvl_q   <= 8'd0;
            drop_cnt_q    <= 8'd0;
            pad_ptr_q     <= 16'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 17'd0;
            wr_data_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            w_bank_q      <= w_bank_d;
            rd_bank_q     <= rd_bank_d;
            frame_ready_q <= frame_ready_d;
            black_lvl_q   <= black_lvl_d;
            drop_cnt_q    <= drop_cnt_d;
            pad_ptr_q     <= pad_ptr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign WR_EN       = wr_en_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
    assign RD_BANK     = rd_bank_q;
    assign FRAME_READY = frame_ready_q;
    assign BLACK_LVL   = black_lvl_q;
    assign DROP_CNT    = drop_cnt_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_frame_bank_sched.sv
// Directed bench for frame_bank_sched: shortened frames (rows 0-3 plus the final pixel)
// exercise writes, black-level substitution, padding, bank swaps, drops and reset.
module tb_frame_bank_sched;

    logic        RESET, WR_CLOCK, FRAME_START, DATA_WREN, FRAME_ACK;
    logic [7:0]  DATA, ROW_NUM, COL_NUM;
    logic        WR_EN, RD_BANK, FRAME_READY;
    logic [16:0] WR_ADDR;
    logic [7:0]  WR_DATA, BLACK_LVL, DROP_CNT;
    logic [1:0]  STATE;

    int checks = 0;
    int passed = 0;

    frame_bank_sched dut (
        .RESET(RESET), .WR_CLOCK(WR_CLOCK), .FRAME_START(FRAME_START),
        .DATA(DATA), .DATA_WREN(DATA_WREN), .ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM),
        .FRAME_ACK(FRAME_ACK), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RD_BANK(RD_BANK), .FRAME_READY(FRAME_READY), .BLACK_LVL(BLACK_LVL),
        .DROP_CNT(DROP_CNT), .STATE(STATE)
    );

    initial WR_CLOCK = 1'b0;
    always #5 WR_CLOCK = ~WR_CLOCK;

    // Inputs change 1 time unit after each rising edge, so outputs are sampled there too.
    task automatic drive_cycle(input logic start, input logic ack);
        FRAME_START = start;
        FRAME_ACK   = ack;
        DATA_WREN   = 1'b0;
        @(posedge WR_CLOCK);
        #1;
        FRAME_START = 1'b0;
        FRAME_ACK   = 1'b0;
    endtask

    task automatic drive_beat(input int r, input int c, input logic [7:0] d);
        DATA_WREN = 1'b1;
        ROW_NUM   = 8'(r);
        COL_NUM   = 8'(c);
        DATA      = d;
        @(posedge WR_CLOCK);
        #1;
        DATA_WREN = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge WR_CLOCK);
        #1;
        RESET = 1'b1;
    endtask

    // Drives a shortened frame up to and including the single pad write; DONE is next.
    task automatic stream_frame(input logic exp_bank, output int writes, output int wrong_bank);
        writes     = 0;
        wrong_bank = 0;
        drive_cycle(1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 250; c++) begin
                drive_beat(r, c, 8'(r + c));
                if (WR_EN) begin
                    writes++;
                    if (WR_ADDR[16] !== exp_bank) wrong_bank++;
                end
            end
        end
        drive_beat(249, 248, 8'h5A);
        if (WR_EN) begin
            writes++;
            if (WR_ADDR[16] !== exp_bank) wrong_bank++;
        end
        drive_cycle(1'b0, 1'b0);
        if (WR_EN) begin
            writes++;
            if (WR_ADDR[16] !== exp_bank) wrong_bank++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge WR_CLOCK);
        #1;
        checks++; if ({WR_EN, WR_ADDR, WR_DATA, RD_BANK, FRAME_READY, BLACK_LVL, DROP_CNT} !== 44'd0) $display("[TB] FAIL reset_outputs: got %h want 0", {WR_EN, WR_ADDR, WR_DATA, RD_BANK, FRAME_READY, BLACK_LVL, DROP_CNT}); else passed++;
        checks++; if (STATE !== 2'd0) $display("[TB] FAIL reset_state: got %0d want 0", STATE); else passed++;
        RESET = 1'b1;
        drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_full_frame();
        int writes;
        logic [7:0] d;
        writes = 0;
        drive_cycle(1'b1, 1'b0);
        checks++; if (STATE !== 2'd1) $display("[TB] FAIL frame1_fill_state: got %0d want 1", STATE); else passed++;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 250; c++) begin
                d = (r == 0 && c == 1) ? 8'h10 : 8'(r + c);
                drive_beat(r, c, d);
                if (WR_EN) writes++;
                if (r == 0 && c == 1) begin
                    checks++; if (BLACK_LVL !== 8'h10) $display("[TB] FAIL frame1_black_lvl: got %h want 10", BLACK_LVL); else passed++;
                    checks++; if ({WR_ADDR, WR_DATA} !== {17'h00001, 8'h10}) $display("[TB] FAIL frame1_pix01: got %h want 0000110", {WR_ADDR, WR_DATA}); else passed++;
                end
                if (r == 1 && c == 5) begin
                    checks++; if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, 17'h000FF, 8'h06}) $display("[TB] FAIL frame1_pix1_5: got %h want %h", {WR_EN, WR_ADDR, WR_DATA}, {1'b1, 17'h000FF, 8'h06}); else passed++;
                end
                if (r == 3 && c == 249) begin
                    checks++; if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, 17'h003E7, 8'h10}) $display("[TB] FAIL frame1_last_col_black: got %h want %h", {WR_EN, WR_ADDR, WR_DATA}, {1'b1, 17'h003E7, 8'h10}); else passed++;
                end
            end
        end
        checks++; if (writes !== 1000) $display("[TB] FAIL frame1_write_count: got %0d want 1000", writes); else passed++;
        drive_beat(249, 248, 8'hAB);
        checks++; if ({WR_ADDR, WR_DATA} !== {17'h0F422, 8'hAB}) $display("[TB] FAIL frame1_final_pixel: got %h want %h", {WR_ADDR, WR_DATA}, {17'h0F422, 8'hAB}); else passed++;
        checks++; if (STATE !== 2'd2) $display("[TB] FAIL frame1_pad_state: got %0d want 2", STATE); else passed++;
        drive_cycle(1'b0, 1'b0);
        checks++; if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, 17'h0F423, 8'h10}) $display("[TB] FAIL frame1_pad_write: got %h want %h", {WR_EN, WR_ADDR, WR_DATA}, {1'b1, 17'h0F423, 8'h10}); else passed++;
        checks++; if (STATE !== 2'd3) $display("[TB] FAIL frame1_done_state: got %0d want 3", STATE); else passed++;
        drive_cycle(1'b0, 1'b0);
        checks++; if ({STATE, FRAME_READY, RD_BANK, DROP_CNT, WR_EN} !== {2'd0, 1'b1, 1'b0, 8'd0, 1'b0}) $display("[TB] FAIL frame1_handoff: got %h want %h", {STATE, FRAME_READY, RD_BANK, DROP_CNT, WR_EN}, {2'd0, 1'b1, 1'b0, 8'd0, 1'b0}); else passed++;
    endtask

    task automatic test_no_ack_drop();
        int writes, wrong;
        stream_frame(1'b1, writes, wrong);
        checks++; if (wrong !== 0) $display("[TB] FAIL frame2_bank1_writes: got %0d wrong-bank writes want 0", wrong); else passed++;
        checks++; if (writes !== 1002) $display("[TB] FAIL frame2_write_count: got %0d want 1002", writes); else passed++;
        drive_cycle(1'b0, 1'b0);
        checks++; if ({DROP_CNT, RD_BANK, FRAME_READY} !== {8'd1, 1'b0, 1'b1}) $display("[TB] FAIL frame2_dropped: got %h want %h", {DROP_CNT, RD_BANK, FRAME_READY}, {8'd1, 1'b0, 1'b1}); else passed++;
        drive_cycle(1'b0, 1'b1);
        checks++; if ({FRAME_READY, RD_BANK} !== 2'b00) $display("[TB] FAIL ack_clears_ready: got %b want 00", {FRAME_READY, RD_BANK}); else passed++;
        stream_frame(1'b1, writes, wrong);
        checks++; if (wrong !== 0) $display("[TB] FAIL frame3_bank1_writes: got %0d wrong-bank writes want 0", wrong); else passed++;
        drive_cycle(1'b0, 1'b0);
        checks++; if ({RD_BANK, FRAME_READY, DROP_CNT} !== {1'b1, 1'b1, 8'd1}) $display("[TB] FAIL frame3_swap: got %h want %h", {RD_BANK, FRAME_READY, DROP_CNT}, {1'b1, 1'b1, 8'd1}); else passed++;
    endtask

    task automatic test_ack_at_done();
        int writes, wrong;
        stream_frame(1'b0, writes, wrong);
        checks++; if (wrong !== 0) $display("[TB] FAIL frame4_bank0_writes: got %0d wrong-bank writes want 0", wrong); else passed++;
        drive_cycle(1'b0, 1'b1);
        checks++; if ({RD_BANK, FRAME_READY, DROP_CNT} !== {1'b0, 1'b1, 8'd1}) $display("[TB] FAIL ack_at_done_swap: got %h want %h", {RD_BANK, FRAME_READY, DROP_CNT}, {1'b0, 1'b1, 8'd1}); else passed++;
    endtask

    task automatic test_abort();
        drive_cycle(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) drive_beat(0, c, 8'(c));
        for (int c = 0; c < 5; c++) drive_beat(100, c, 8'hC0);
        checks++; if ({WR_EN, WR_ADDR} !== {1'b1, 17'h161AC}) $display("[TB] FAIL abort_row100_addr: got %h want %h", {WR_EN, WR_ADDR}, {1'b1, 17'h161AC}); else passed++;
        drive_cycle(1'b1, 1'b0);
        checks++; if ({STATE, DROP_CNT, WR_EN, RD_BANK, FRAME_READY} !== {2'd1, 8'd2, 1'b0, 1'b0, 1'b1}) $display("[TB] FAIL abort_status: got %h want %h", {STATE, DROP_CNT, WR_EN, RD_BANK, FRAME_READY}, {2'd1, 8'd2, 1'b0, 1'b0, 1'b1}); else passed++;
        drive_beat(0, 0, 8'h55);
        checks++; if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, 17'h10000, 8'h55}) $display("[TB] FAIL abort_restart_write: got %h want %h", {WR_EN, WR_ADDR, WR_DATA}, {1'b1, 17'h10000, 8'h55}); else passed++;
    endtask

    task automatic test_reset_mid_fill();
        for (int c = 1; c < 4; c++) drive_beat(0, c, 8'h33);
        RESET = 1'b0;
        #2;
        checks++; if ({WR_EN, WR_ADDR, WR_DATA, RD_BANK, FRAME_READY, BLACK_LVL, DROP_CNT, STATE} !== 46'd0) $display("[TB] FAIL reset_mid_fill: got %h want 0", {WR_EN, WR_ADDR, WR_DATA, RD_BANK, FRAME_READY, BLACK_LVL, DROP_CNT, STATE}); else passed++;
        @(posedge WR_CLOCK);
        #1;
        RESET = 1'b1;
        drive_cycle(1'b1, 1'b0);
        drive_beat(0, 2, 8'h77);
        checks++; if ({WR_EN, WR_ADDR, WR_DATA} !== {1'b1, 17'h00002, 8'h77}) $display("[TB] FAIL post_reset_bank0: got %h want %h", {WR_EN, WR_ADDR, WR_DATA}, {1'b1, 17'h00002, 8'h77}); else passed++;
    endtask

    task automatic test_invalid_beats();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive_beat(250, i, 8'hEE);
            if (WR_EN) pulses++;
            drive_beat(i, 250, 8'hEE);
            if (WR_EN) pulses++;
            drive_beat(255, 255, 8'hEE);
            if (WR_EN) pulses++;
        end
        checks++; if ({pulses, STATE} !== {32'd0, 2'd1}) $display("[TB] FAIL out_of_range_writes: got %0d pulses state %0d want 0 and 1", pulses, STATE); else passed++;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            drive_beat(0, c, 8'h44);
            if (WR_EN) pulses++;
        end
        checks++; if ({pulses, STATE} !== {32'd0, 2'd0}) $display("[TB] FAIL idle_writes: got %0d pulses state %0d want 0 and 0", pulses, STATE); else passed++;
    endtask

    task automatic test_drop_saturation();
        drive_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 255; i++) begin
            drive_cycle(1'b1, 1'b0);
            if (i == 1) begin
                checks++; if (DROP_CNT !== 8'd1) $display("[TB] FAIL drop_first_abort: got %0d want 1", DROP_CNT); else passed++;
            end
        end
        checks++; if (DROP_CNT !== 8'd255) $display("[TB] FAIL drop_reach_255: got %0d want 255", DROP_CNT); else passed++;
        drive_cycle(1'b1, 1'b0);
        checks++; if ({DROP_CNT, STATE} !== {8'd255, 2'd1}) $display("[TB] FAIL drop_saturate: got %0d state %0d want 255 and 1", DROP_CNT, STATE); else passed++;
    endtask

    initial begin
        RESET       = 1'b0;
        FRAME_START = 1'b0;
        DATA_WREN   = 1'b0;
        FRAME_ACK   = 1'b0;
        DATA        = 8'd0;
        ROW_NUM     = 8'd0;
        COL_NUM     = 8'd0;
        test_reset();
        test_full_frame();
        test_no_ack_drop();
        test_ack_at_done();
        test_abort();
        test_reset_mid_fill();
        test_invalid_beats();
        test_drop_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/frame_bank_sched.md
Name: frame_bank_sched

Overview:
- Ping-pong scheduler for the 250x250 8-bit frame RAM: two banks, selected by address bit 16.
- Converts the sensor pixel stream (DATA/ROW_NUM/COL_NUM) into RAM write commands for the current write bank.
- Substitutes black level into the last column and pads the frame tail.
- Hands completed banks to the readout side via a READY/ACK handshake; reader handshake signals are already synchronised to WR_CLOCK.

Parameters:
- COLS, 250, pixels per row
- ROWS, 250, rows per frame
- PIXELS, 62500, bank size in words (COLS*ROWS)

Ports:
- RESET  in  1  asynchronous, active-low reset
- WR_CLOCK  in  1  pixel/write clock; all logic on rising edge
- FRAME_START  in  1  one-cycle pulse, start of sensor frame
- DATA  in  8  pixel value
- DATA_WREN  in  1  DATA/ROW_NUM/COL_NUM valid
- ROW_NUM  in  8  pixel row
- COL_NUM  in  8  pixel column
- FRAME_ACK  in  1  one-cycle pulse, reader releases RD_BANK
- WR_EN  out  1  RAM write enable
- WR_ADDR  out  17  {bank, offset[15:0]}
- WR_DATA  out  8  RAM write data
- RD_BANK  out  1  bank the reader may read
- FRAME_READY  out  1  RD_BANK holds an unread complete frame
- BLACK_LVL  out  8  black level latched from the current frame
- DROP_CNT  out  8  dropped/aborted frames, saturates at 255
- STATE  out  2  IDLE=0, FILL=1, PAD=2, DONE=3

Behaviour:
- Reset values: all outputs 0, internal w_bank=0, STATE=IDLE.
- Register outputs; WR_EN/WR_ADDR/WR_DATA appear 1 cycle after the qualifying input.
- Offset = ROW_NUM*COLS+COL_NUM, computed 16-bit unsigned. WR_ADDR = {w_bank, offset}.

State machine:
- IDLE: DATA_WREN ignored. FRAME_START -> FILL.
- FILL, on each DATA_WREN with ROW_NUM<ROWS and COL_NUM<COLS:
  - COL_NUM<COLS-1: write DATA.
  - COL_NUM==COLS-1: write BLACK_LVL.
  - (ROW,COL)==(0,1): write DATA and latch BLACK_LVL<=DATA in the same cycle.
  - Out-of-range coordinates: no write.
  - Write of (ROWS-1, COLS-2) -> PAD, with pad pointer = that offset+1.
- PAD: ignore the stream. Write BLACK_LVL at pad pointer, one per cycle, incrementing until offset PIXELS-1 is written (default: single write at 62499). Then -> DONE.
- DONE, one cycle, then -> IDLE:
  - If FRAME_READY==0, or FRAME_ACK is asserted this cycle: RD_BANK<=w_bank, w_bank<=~w_bank, FRAME_READY<=1.
  - Else: no swap, next frame overwrites the same bank, DROP_CNT+1.
- FRAME_START in FILL or PAD: abort. No swap, DROP_CNT+1, -> FILL in the same bank; the pulse starts the new frame.
- FRAME_START in DONE: DONE completes, then -> FILL directly (start not lost).

Handshake:
- FRAME_ACK with FRAME_READY=1 (outside the DONE swap case): FRAME_READY<=0 next cycle. RD_BANK is unchanged until the next swap.
- FRAME_ACK with FRAME_READY=0: ignored.

Other rules:
- WR_EN is never asserted on the bank equal to RD_BANK while FRAME_READY=1.
- Reset mid-frame: immediate return to reset values; partial frame discarded.
- DROP_CNT saturates at 255; no wrap.

Test Plan:
- Reset: assert RESET mid-FILL -> all outputs 0, STATE=0, next FRAME_START writes bank 0.
- Full frame, DATA=(row+col)&0xFF, (0,1)=0x10:
  - BLACK_LVL=0x10.
  - WR_ADDR=0x003E7 (row3,col249) gets 0x10.
  - Pixel (1,5) written 0x06 at 0x000FF.
  - PAD writes 0x10 at 0x0F423.
  - FRAME_READY=1, RD_BANK=0 the cycle after DONE.
- Second full frame, no ACK -> all writes in 0x1xxxx, DROP_CNT=1, RD_BANK=0, FRAME_READY stays 1. Third frame after one ACK pulse -> RD_BANK=1, FRAME_READY=1.
- FRAME_START at row 100 of FILL -> DROP_CNT increments, STATE stays FILL, no swap, subsequent writes restart at offset 0 of the same bank.
- FRAME_ACK coincident with DONE while FRAME_READY=1 -> swap occurs, FRAME_READY remains 1, RD_BANK toggles, DROP_CNT unchanged.
- Stream with COL_NUM=250 and ROW_NUM=250 beats, plus DATA_WREN while IDLE -> no WR_EN pulses; 256 dropped frames -> DROP_CNT=255.
